iob_rr_arbiter: RTL and testbench
=================================

// Module: iob_rr_arbiter
// PURPOSE
//   Round-robin arbiter sharing one native (valid/ready) slave port among N_MASTERS native masters.
//   Typical use: several cores/DMAs sharing a single iob2axil bridge to an AXI4-Lite bus.
//   Grants one transaction at a time and latches the winner's request for the whole transaction.
//   Rotates priority after every completed transaction.
// PARAMETERS
//   N_MASTERS  2   number of requesting masters (>=2)
//   ADDR_W     32  address width
//   DATA_W     32  data width (multiple of 8)
//   GNT_W      $clog2(N_MASTERS)  grant index width (derived, not overridden)
// PORTS
//   clk        in   1                  clock
//   rst        in   1                  reset, asynchronous, active-high
//   m_valid    in   N_MASTERS          per-master request; held high until its m_ready
//   m_addr     in   N_MASTERS*ADDR_W   packed addresses; master i at [i*ADDR_W +: ADDR_W]
//   m_wdata    in   N_MASTERS*DATA_W   packed write data
//   m_wstrb    in   N_MASTERS*DATA_W/8 packed byte strobes; nonzero = write, zero = read
//   m_rdata    out  DATA_W             read data, broadcast to all masters; valid with m_ready
//   m_ready    out  N_MASTERS          one-hot completion pulse to the granted master
//   s_valid    out  1                  request to shared slave
//   s_addr     out  ADDR_W             latched address of granted master
//   s_wdata    out  DATA_W             latched write data
//   s_wstrb    out  DATA_W/8           latched strobes
//   s_rdata    in   DATA_W             slave read data
//   s_ready    in   1                  slave completion pulse
//   grant      out  GNT_W              index of current/last granted master
//   busy       out  1                  high while a transaction is outstanding (BUSY state)
// BEHAVIOUR
//   Reset: state=IDLE, s_valid=0, s_addr/s_wdata/s_wstrb=0, grant=0, priority pointer=0, busy=0.
//     m_ready=0 whenever not BUSY. Reset mid-transaction abandons it; no m_ready pulse is issued.
//   FSM, 2 states:
//     IDLE: if |m_valid, pick first i with m_valid[i]=1 scanning ptr, ptr+1, ... wrapping mod N_MASTERS.
//       On the clock edge: grant<=i, latch m_addr/m_wdata/m_wstrb of i into s_*,
//       s_valid<=1, busy<=1, ->BUSY. If no request, stay IDLE.
//     BUSY: s_valid held 1 and s_* held constant; m_valid changes are ignored.
//       m_ready[grant] = s_ready (combinational, same cycle); m_rdata = s_rdata always.
//       On s_ready: s_valid<=0, busy<=0, ptr <= grant+1 (grant==N_MASTERS-1 wraps to 0), ->IDLE.
//   Latency: request seen in IDLE at cycle t -> s_valid=1 at t+1. Completion cycle c -> IDLE at c+1.
//     Next arbitration in IDLE at c+1, so a new s_valid at the earliest at c+2.
//     This gives the finishing master one cycle to drop or renew m_valid before re-arbitration.
//   Simultaneous requests: resolved purely by ptr order. No master waits more than N_MASTERS-1 grants.
//   s_ready while IDLE: ignored, no m_ready pulse.
//   Single requester: it is granted back-to-back, one transaction every (slave latency + 2) cycles.
//   Write vs read: no distinction by arbiter; a write completes when the slave pulses s_ready.
//     The slave may continue internally (e.g. AXI write response); the arbiter holds no state for it.
//   Widths: packed slices are selected by grant with indexed part-select; no arithmetic beyond the ptr increment.
// TESTING
//   N_MASTERS=3: reset asserted while BUSY -> s_valid=0, busy=0, grant=0, no m_ready pulse; first post-reset grant goes to master 0.
//   Only m1 requests addr 0x10, wstrb 0xF, wdata 0xDEADBEEF -> s_* equal these one cycle later; s_ready -> m_ready=3'b010 same cycle; ptr=2.
//   m0,m1,m2 all request continuously -> grant sequence 0,1,2,0,1,2; every master is served once per 3 transactions.
//   m0 read granted, slave returns s_rdata=0x12345678 with s_ready after 5 cycles -> m_rdata=0x12345678 and m_ready[0]=1 in that cycle only.
//   m2 changes m_addr and drops m_valid while BUSY -> s_addr unchanged and s_valid stays 1 until s_ready.
//   s_ready pulsed in IDLE with no request -> m_ready=0, state stays IDLE.

Source files
------------

// File: rtl/iob_rr_arbiter.sv
// Round-robin arbiter that shares one native valid/ready slave port among N_MASTERS masters.
// The winner's request is latched for the whole transaction; priority rotates past it on completion.
module iob_rr_arbiter #(
  parameter  int N_MASTERS = 2,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  localparam int GNT_W     = $clog2(N_MASTERS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [N_MASTERS-1:0]          m_ready,
  output logic                          s_valid,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [DATA_W/8-1:0]           s_wstrb,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_ready,
  output logic [GNT_W-1:0]              grant,
  output logic                          busy
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [GNT_W-1:0]   r_ptr;
  logic [GNT_W-1:0]   w_ptr_nxt;
  logic [GNT_W-1:0]   r_grant;
  logic [GNT_W-1:0]   w_pick;
  logic               w_load;
  logic               w_busy;
  logic [ADDR_W-1:0]  r_s_addr;
  logic [DATA_W-1:0]  r_s_wdata;
  logic [STRB_W-1:0]  r_s_wstrb;
  int                 w_off;
  int                 w_best;

  // Winner = requester with the smallest circular distance from the priority pointer.
  // NOTE: every variable gets a default before any branch so always_comb never infers a latch.
  always_comb begin
    w_pick = r_ptr;
    w_best = N_MASTERS;
    w_off  = 0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (m_valid[i]) begin
        w_off = i - int'(r_ptr);
        if (w_off < 0) w_off = w_off + N_MASTERS;
        if (w_off < w_best) begin
          w_best = w_off;
          w_pick = GNT_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (|m_valid) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (s_ready) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = (r_grant == GNT_W'(N_MASTERS - 1)) ? '0 : r_grant + GNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_busy = (r_state == ST_BUSY);
  assign w_load = (r_state == ST_IDLE) && (|m_valid);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // NOTE: the latched request is reset too, so the slave port shows zeros rather than X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant   <= '0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_s_wstrb <= '0;
    end else if (w_load) begin
      r_grant   <= w_pick;
      r_s_addr  <= m_addr[w_pick*ADDR_W +: ADDR_W];
      r_s_wdata <= m_wdata[w_pick*DATA_W +: DATA_W];
      r_s_wstrb <= m_wstrb[w_pick*STRB_W +: STRB_W];
    end
  end

  // Completion is passed straight through to the owner in the same cycle as s_ready.
  always_comb begin
    m_ready = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      m_ready[i] = w_busy && s_ready && (r_grant == GNT_W'(i));
    end
  end

  assign m_rdata = s_rdata;
  assign s_valid = w_busy;
  assign busy    = w_busy;
  assign grant   = r_grant;
  assign s_addr  = r_s_addr;
  assign s_wdata = r_s_wdata;
  assign s_wstrb = r_s_wstrb;

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// Bench for iob_rr_arbiter (3 masters): directed scenarios followed by randomized traffic,
// with a reference model feeding a scoreboard that a negedge monitor drains.
module tb_iob_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_valid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    m_ready;
  logic            s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic [DW-1:0]   s_rdata;
  logic            s_ready;
  logic [1:0]      grant;
  logic            busy;

  iob_rr_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .m_valid (m_valid),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .s_valid (s_valid),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_rdata (s_rdata),
    .s_ready (s_ready),
    .grant   (grant),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            master;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  txn_t mdl_txn;

  // Reference model: one outstanding transaction, winner = first requester at or after the pointer.
  bit mdl_busy  = 1'b0;
  int mdl_ptr   = 0;
  int mdl_grant = 0;
  int mdl_i     = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_busy  = 1'b0;
      mdl_ptr   = 0;
      mdl_grant = 0;
      exp_q.delete();
    end else if (!mdl_busy) begin
      for (int k = 0; k < N; k++) begin
        mdl_i = (mdl_ptr + k) % N;
        if (!mdl_busy && m_valid[mdl_i]) begin
          mdl_busy        = 1'b1;
          mdl_grant       = mdl_i;
          mdl_txn.master  = mdl_i;
          mdl_txn.addr    = m_addr[mdl_i*AW +: AW];
          mdl_txn.wdata   = m_wdata[mdl_i*DW +: DW];
          mdl_txn.wstrb   = m_wstrb[mdl_i*SW +: SW];
          exp_q.push_back(mdl_txn);
        end
      end
    end else if (s_ready) begin
      mdl_ptr  = (mdl_grant + 1) % N;
      mdl_busy = 1'b0;
    end
  end

  logic         s_valid_q = 1'b0;
  logic [N-1:0] m_ready_q = '0;
  logic         prev_sv   = 1'b0;
  logic [N-1:0] exp_rdy;

  always @(negedge clk) begin
    s_valid_q = s_valid;
    m_ready_q = m_ready;
    exp_rdy   = (mdl_busy && s_ready) ? N'(1 << mdl_grant) : '0;
    check("mon_grant",   grant,   mdl_grant);
    check("mon_busy",    busy,    mdl_busy);
    check("mon_s_valid", s_valid, mdl_busy);
    check("mon_m_ready", m_ready, exp_rdy);
    check("mon_m_rdata", m_rdata, s_rdata);
    if (s_valid && !prev_sv) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL mon_pop actual=s_valid_rise required=queued_transaction");
      end else begin
        cur = exp_q.pop_front();
      end
    end
    if (s_valid) begin
      check("mon_s_addr",  s_addr,  cur.addr);
      check("mon_s_wdata", s_wdata, cur.wdata);
      check("mon_s_wstrb", s_wstrb, cur.wstrb);
      check("mon_owner",   grant,   cur.master);
    end
    prev_sv = s_valid;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
    m_valid[i]         = 1'b1;
    m_addr[i*AW +: AW] = a;
    m_wdata[i*DW +: DW] = d;
    m_wstrb[i*SW +: SW] = s;
  endtask

  task automatic rand_payload(input int i);
    m_addr[i*AW +: AW]  = $urandom;
    m_wdata[i*DW +: DW] = $urandom;
    m_wstrb[i*SW +: SW] = SW'($urandom_range(0, 15));
  endtask

  // Returns at the negedge of the first cycle with s_valid high, or after a bounded wait.
  task automatic wait_busy(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (s_valid) ok = 1'b1;
      else cyc();
    end
    check({name, "_s_valid"}, s_valid, 1'b1);
  endtask

  // Pulses s_ready for one cycle from a busy negedge; returns at +1 after the IDLE-cycle edge.
  task automatic complete(input logic [DW-1:0] rdata, input logic [N-1:0] exp, input string name);
    cyc();
    s_ready = 1'b1;
    s_rdata = rdata;
    @(negedge clk);
    check({name, "_m_ready"}, m_ready, exp);
    check({name, "_m_rdata"}, m_rdata, rdata);
    cyc();
    s_ready = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  started;
    rst     = 1'b1;
    m_valid = '0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    s_rdata = '0;
    s_ready = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_valid", s_valid, 1'b0);
    check("rst_busy",    busy,    1'b0);
    check("rst_grant",   grant,   2'd0);
    check("rst_s_addr",  s_addr,  32'h0);
    check("rst_s_wdata", s_wdata, 32'h0);
    check("rst_s_wstrb", s_wstrb, 4'h0);
    check("rst_m_ready", m_ready, 3'b000);

    // Reset while BUSY abandons the transaction.
    cyc();
    set_req(2, 32'hA0, 32'h1111_2222, 4'h3);
    wait_busy("t1_busy");
    check("t1_grant", grant, 2'd2);
    cyc();
    rst     = 1'b1;
    s_ready = 1'b1;
    @(negedge clk);
    check("t1_rst_s_valid", s_valid, 1'b0);
    check("t1_rst_busy",    busy,    1'b0);
    check("t1_rst_grant",   grant,   2'd0);
    check("t1_rst_m_ready", m_ready, 3'b000);
    cyc();
    rst     = 1'b0;
    s_ready = 1'b0;
    set_req(0, 32'hB0, 32'h3333_4444, 4'h1);
    set_req(1, 32'hC0, 32'h5555_6666, 4'h0);
    wait_busy("t1_post");
    check("t1_post_grant", grant, 2'd0);
    complete(32'h0, 3'b001, "t1");
    m_valid = '0;

    // Single requester m1.
    set_req(1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    wait_busy("t2");
    check("t2_s_addr",  s_addr,  32'h10);
    check("t2_s_wdata", s_wdata, 32'hDEAD_BEEF);
    check("t2_s_wstrb", s_wstrb, 4'hF);
    check("t2_grant",   grant,   2'd1);
    complete(32'h0, 3'b010, "t2");
    m_valid = '0;

    // Pointer is now 2: m2 beats m0.
    set_req(0, 32'h20, 32'h0, 4'h0);
    set_req(2, 32'h30, 32'h0, 4'h0);
    wait_busy("t2_ptr");
    check("t2_ptr_grant", grant, 2'd2);
    complete(32'h0, 3'b100, "t2_ptr");

    // All three request continuously.
    set_req(1, 32'h40, 32'h0, 4'h2);
    for (int k = 0; k < 6; k++) begin
      wait_busy("t3");
      check("t3_grant", grant, k % 3);
      complete($urandom, N'(1 << (k % 3)), "t3");
    end
    m_valid = '0;

    // m0 read with five-cycle slave latency.
    set_req(0, 32'h50, 32'h0, 4'h0);
    wait_busy("t4");
    check("t4_grant", grant,   2'd0);
    check("t4_wstrb", s_wstrb, 4'h0);
    for (int j = 0; j < 4; j++) begin
      cyc();
      @(negedge clk);
      check("t4_wait_m_ready", m_ready, 3'b000);
    end
    complete(32'h1234_5678, 3'b001, "t4");
    m_valid = '0;
    @(negedge clk);
    check("t4_after_m_ready", m_ready, 3'b000);

    // m2 changes its request while BUSY; the latched one is kept.
    cyc();
    set_req(2, 32'h200, 32'hCAFE_0000, 4'h8);
    wait_busy("t5");
    check("t5_grant", grant, 2'd2);
    for (int j = 0; j < 3; j++) begin
      cyc();
      if (j == 0) begin
        m_addr[2*AW +: AW] = 32'h300;
        m_valid[2]         = 1'b0;
      end
      @(negedge clk);
      check("t5_s_addr",  s_addr,  32'h200);
      check("t5_s_valid", s_valid, 1'b1);
    end
    complete(32'h0, 3'b100, "t5");

    // s_ready in IDLE is ignored.
    cyc();
    s_ready = 1'b1;
    @(negedge clk);
    check("t6_m_ready", m_ready, 3'b000);
    check("t6_busy",    busy,    1'b0);
    cyc();
    s_ready = 1'b0;
    @(negedge clk);
    check("t6_s_valid", s_valid, 1'b0);

    // Randomized traffic with occasional resets.
    started = 1'b0;
    lat     = 0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 499) == 0) begin
        rst     = 1'b1;
        s_ready = 1'b0;
        started = 1'b0;
      end else begin
        if (s_ready) begin
          s_ready = 1'b0;
          started = 1'b0;
        end else if (s_valid_q) begin
          if (!started) begin
            started = 1'b1;
            lat     = $urandom_range(0, 4);
          end
          if (lat == 0) begin
            s_ready = 1'b1;
            s_rdata = $urandom;
            started = 1'b0;
          end else begin
            lat--;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          s_ready = 1'b1;
          s_rdata = $urandom;
        end
        for (int i = 0; i < N; i++) begin
          if (m_valid[i] && m_ready_q[i]) begin
            if ($urandom_range(0, 1) == 0) m_valid[i] = 1'b0;
            else rand_payload(i);
          end else if (!m_valid[i]) begin
            if ($urandom_range(0, 2) == 0) begin
              m_valid[i] = 1'b1;
              rand_payload(i);
            end
          end else if ($urandom_range(0, 7) == 0) begin
            rand_payload(i);
          end
        end
      end
    end

    cyc();
    rst     = 1'b0;
    m_valid = '0;
    s_ready = 1'b0;
    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
